io_uart: RTL and testbench
==========================

Name: io_uart

Overview:
- Memory-mapped 8N1 UART IO core occupying IO slot #2, directly downstream of the IO interconnect.
- Consumes the interconnect's slave-side bus (rd_en, wr_en, cs, address, wr_data) and returns registered read data on io_bus_uart_rd_data.
- Contains TX and RX FIFOs, a programmable 16x-oversampling baud tick generator, and TX and RX bit-level state machines.

Parameters:
- FIFO_DEPTH, 16, entries per TX and RX FIFO; must be a power of 2 and at least 2.
- DEFAULT_DIVISOR, 26, reset value of the DIVISOR register. One baud tick every DIVISOR+1 clocks (50 MHz gives 115200 baud at 16x).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (block is in reset while rst=0)
- io_bus_s_rd_en  in  1  read strobe
- io_bus_s_wr_en  in  1  write strobe
- io_bus_s_cs  in  1  this slot's chip-select bit (io_bus_s_cs[2] at the interconnect)
- io_bus_s_address  in  32  byte address; only bits [3:2] are decoded
- io_bus_s_wr_data  in  32  write data
- io_bus_uart_rd_data  out  32  registered read data
- uart_tx  out  1  serial output, idles high
- uart_rx  in  1  serial input, asynchronous

Behaviour:
- Access qualification: an access occurs only when cs=1 and rd_en=1 or wr_en=1. With cs=0 the block ignores all bus inputs.
- Read latency: io_bus_uart_rd_data is updated one clock after a qualified read. In every other cycle it is 0.
- Register map, address[3:2]:
  - 0 DATA. Write pushes wr_data[7:0] into the TX FIFO. The push is accepted iff the TX FIFO is not full in that cycle; otherwise the byte is silently dropped. Read returns {23'b0, rx_empty, rx_byte} and pops the RX FIFO if it is non-empty. A read of an empty RX FIFO returns 0x100 and leaves the pointers unchanged.
  - 1 STATUS (read-only). Bit 0 tx_full; bit 1 tx_idle (TX FIFO empty and TX FSM in IDLE); bit 2 rx_empty; bit 3 rx_full; bit 4 overrun (sticky); bit 5 frame_err (sticky). All other bits read 0.
  - 2 DIVISOR. 16-bit R/W, upper bits read 0. A write also zeroes the tick counter.
  - 3 CLEAR (write-only, reads 0). wr_data[0]=1 clears overrun; wr_data[1]=1 clears frame_err.
- Reset values: uart_tx=1, io_bus_uart_rd_data=0, both FIFOs empty, sticky flags 0, DIVISOR=DEFAULT_DIVISOR, tick counter 0, both FSMs in IDLE, RX synchronizer flops 1.
- Baud tick: a single-cycle pulse whenever the counter equals DIVISOR. The counter then wraps to 0.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - Each bit lasts 16 ticks; data is sent LSB first.
  - IDLE leaves on the first tick with the TX FIFO non-empty, popping one byte in that cycle.
  - STOP returns to IDLE, or goes directly to START (popping the next byte) if the FIFO is non-empty.
- RX path: uart_rx passes through a 2-flop synchronizer.
- RX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: on a tick with synced rx=0, enter START and reset the sub-tick count.
  - START: after 8 ticks, sample. If rx=1 (glitch), return to IDLE with no push; if rx=0, go to DATA.
  - DATA: sample every 16 ticks, 8 bits, LSB first.
  - STOP: sample after 16 ticks.
    - rx=1 and RX FIFO not full: push the byte.
    - rx=1 and RX FIFO full: drop the byte and set overrun.
    - rx=0: drop the byte and set frame_err.
  - Return to IDLE after STOP in all cases.
- Simultaneous events:
  - A CLEAR write in the same cycle as a flag set: the set wins.
  - A bus pop and an RX push in the same cycle are both performed.
  - A DIVISOR write mid-frame is allowed; the in-flight frame is corrupted, with no other side effect.
- Reset mid-frame: the block returns immediately to reset values and uart_tx goes high asynchronously.

Decomposition:
- Shared package defines.svh:
  - UART_SLOT = 2
  - Register offsets UART_REG_DATA/STATUS/DIVISOR/CLEAR
  - STATUS bit indices
  - uart_tx_state_t and uart_rx_state_t enums
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Ports: push, pop, wr_data, rd_data (first-word fall-through), full, empty.
  - Instantiated twice: TX and RX FIFOs.
  - Reusable by other IO cores.

Test Plan:
- Reset: release rst, read STATUS -> 0x06 one cycle later; uart_tx=1; read DIVISOR -> 26.
- TX frame: write DIVISOR=3, then DATA=0xA5 -> uart_tx low for 64 clocks, then bits 1,0,1,0,0,1,0,1 (64 clocks each), then high 64 clocks; STATUS bit1 returns to 1.
- Loopback: tie uart_tx to uart_rx, send 0x3C -> after the frame, STATUS bit2=0; DATA read -> 0x03C; next DATA read -> 0x100.
- Overrun: drive 17 frames into uart_rx without reading -> STATUS=0x1A (overrun, rx_full, tx_idle); 16 reads return the first 16 bytes in order; write CLEAR=1 -> bit4 clears.
- Frame error and glitch: a frame with low stop bit -> frame_err=1 and RX FIFO stays empty; a 3-tick low pulse -> no push and no flags set.
- TX full: with DIVISOR=3, write 18 bytes back-to-back -> tx_full=1 after the 17th write; the 18th byte never appears on uart_tx.

Source files
------------

// File: rtl/io_uart_pkg.sv
// io_uart_pkg: shared constants, register map, status bit indices and FSM state types for the IO UART.
package io_uart_pkg;

    localparam int UART_SLOT = 2;

    localparam logic [1:0] UART_REG_DATA    = 2'd0;
    localparam logic [1:0] UART_REG_STATUS  = 2'd1;
    localparam logic [1:0] UART_REG_DIVISOR = 2'd2;
    localparam logic [1:0] UART_REG_CLEAR   = 2'd3;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_IDLE   = 1;
    localparam int ST_RX_EMPTY  = 2;
    localparam int ST_RX_FULL   = 3;
    localparam int ST_OVERRUN   = 4;
    localparam int ST_FRAME_ERR = 5;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} uart_tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_rx_state_t;

endpackage

// File: rtl/io_uart_sync_fifo.sv
// sync_fifo: synchronous first-word-fall-through FIFO, reusable by IO cores.
// Ports: clk, rst (async active-low), push/wr_data write side (ignored when full),
// pop (ignored when empty), rd_data always shows the oldest entry, full/empty flags.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    always_comb begin
        empty    = wr_ptr_q == rd_ptr_q;
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/io_uart.sv
// io_uart: memory-mapped 8N1 UART for IO slot 2 with TX/RX FIFOs and a 16x baud tick.
// Ports: clk, rst (async active-low); io_bus_s_* slave bus (rd_en, wr_en, cs, address, wr_data);
// io_bus_uart_rd_data registered read data (zero except the cycle after a read);
// uart_tx serial out (idles high); uart_rx asynchronous serial in.
module io_uart
    import io_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH      = 16,
    parameter int unsigned DEFAULT_DIVISOR = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_bus_s_rd_en,
    input  logic        io_bus_s_wr_en,
    input  logic        io_bus_s_cs,
    input  logic [31:0] io_bus_s_address,
    input  logic [31:0] io_bus_s_wr_data,
    output logic [31:0] io_bus_uart_rd_data,
    output logic        uart_tx,
    input  logic        uart_rx
);
    logic        rd_acc, wr_acc, tx_push, rx_pop, div_wr, clr_wr, tick;
    logic [1:0]  reg_sel;
    logic [15:0] div_q, div_d, cnt_q, cnt_d;
    logic        tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push, tx_idle;
    logic [7:0]  tx_fifo_data, rx_fifo_data;
    logic        ovr_q, ovr_d, fe_q, fe_d, ovr_set, fe_set;
    logic [31:0] rd_data_q, rd_data_d, status;

    uart_tx_state_t tx_state_q, tx_state_d;
    logic [3:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]     tx_bit_q, tx_bit_d;
    logic [7:0]     tx_shift_q, tx_shift_d;
    logic           tx_line_q, tx_line_d;

    uart_rx_state_t rx_state_q, rx_state_d;
    logic [3:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]     rx_bit_q, rx_bit_d;
    logic [7:0]     rx_shift_q, rx_shift_d;
    logic [1:0]     sync_q, sync_d;
    logic           rx_s;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{io_bus_s_address[31:4], io_bus_s_address[1:0], io_bus_s_wr_data[31:16]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wr_data(io_bus_s_wr_data[7:0]),
        .rd_data(tx_fifo_data), .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wr_data(rx_shift_q),
        .rd_data(rx_fifo_data), .full(rx_full), .empty(rx_empty)
    );

    // Bus decode and baud tick.
    always_comb begin
        rd_acc  = io_bus_s_cs && io_bus_s_rd_en;
        wr_acc  = io_bus_s_cs && io_bus_s_wr_en;
        reg_sel = io_bus_s_address[3:2];
        tx_push = wr_acc && reg_sel == UART_REG_DATA;
        rx_pop  = rd_acc && reg_sel == UART_REG_DATA;
        div_wr  = wr_acc && reg_sel == UART_REG_DIVISOR;
        clr_wr  = wr_acc && reg_sel == UART_REG_CLEAR;
        tick    = cnt_q == div_q;
        cnt_d   = (div_wr || tick) ? '0 : cnt_q + 16'd1;
        div_d   = div_wr ? io_bus_s_wr_data[15:0] : div_q;
        sync_d  = {sync_q[0], uart_rx};
        rx_s    = sync_q[1];
    end

    // TX FSM: the bit counter free-runs on ticks and every bit ends when it wraps.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        if (tick) begin
            tx_cnt_d = tx_cnt_q + 4'd1;
            case (tx_state_q)
                TX_IDLE: if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_fifo_data;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
                TX_START: if (tx_cnt_q == 4'd15) begin
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
                TX_DATA: if (tx_cnt_q == 4'd15) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_state_d = tx_bit_q == 3'd7 ? TX_STOP : TX_DATA;
                end
                TX_STOP: if (tx_cnt_q == 4'd15) begin
                    tx_pop     = !tx_empty;
                    tx_shift_d = tx_empty ? tx_shift_q : tx_fifo_data;
                    tx_state_d = tx_empty ? TX_IDLE : TX_START;
                end
                default: tx_state_d = TX_IDLE;
            endcase
        end
        // The line is registered from the next state so it changes glitch-free with the FSM.
        tx_line_d = tx_state_d == TX_START ? 1'b0 : tx_state_d == TX_DATA ? tx_shift_d[0] : 1'b1;
        tx_idle   = tx_empty && tx_state_q == TX_IDLE;
    end

    // RX FSM: sample mid-start after 8 ticks, then mid-bit every 16 ticks.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        fe_set     = 1'b0;
        if (tick) begin
            rx_cnt_d = rx_cnt_q + 4'd1;
            case (rx_state_q)
                RX_IDLE: if (!rx_s) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
                RX_START: if (rx_cnt_q == 4'd7) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_cnt_q == 4'd15) begin
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    rx_state_d = rx_bit_q == 3'd7 ? RX_STOP : RX_DATA;
                end
                RX_STOP: if (rx_cnt_q == 4'd15) begin
                    fe_set     = !rx_s;
                    ovr_set    = rx_s && rx_full;
                    rx_push    = rx_s && !rx_full;
                    rx_state_d = RX_IDLE;
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    // Sticky flags (a set beats a simultaneous clear) and registered read data.
    always_comb begin
        ovr_d  = ovr_set || (ovr_q && !(clr_wr && io_bus_s_wr_data[0]));
        fe_d   = fe_set || (fe_q && !(clr_wr && io_bus_s_wr_data[1]));
        status = '0;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_IDLE]   = tx_idle;
        status[ST_RX_EMPTY]  = rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_OVERRUN]   = ovr_q;
        status[ST_FRAME_ERR] = fe_q;
        rd_data_d = !rd_acc                      ? '0 :
                    reg_sel == UART_REG_DATA     ? {23'd0, rx_empty, rx_empty ? 8'd0 : rx_fifo_data} :
                    reg_sel == UART_REG_STATUS   ? status :
                    reg_sel == UART_REG_DIVISOR  ? {16'd0, div_q} : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q      <= 16'(DEFAULT_DIVISOR);
            cnt_q      <= '0;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
            rd_data_q  <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            sync_q     <= 2'b11;
        end else begin
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            ovr_q      <= ovr_d;
            fe_q       <= fe_d;
            rd_data_q  <= rd_data_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            sync_q     <= sync_d;
        end
    end

    assign io_bus_uart_rd_data = rd_data_q;
    assign uart_tx             = tx_line_q;

endmodule

// File: tb/tb_io_uart.sv
// tb_io_uart: randomized self-checking bench for io_uart with a queue-based serial/register model.
module tb_io_uart;
    localparam logic [1:0] R_DATA = 2'd0, R_STATUS = 2'd1, R_DIV = 2'd2, R_CLEAR = 2'd3;

    logic        clk = 1'b0, rst = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0, cs = 1'b0;
    logic [31:0] address = '0, wr_data = '0, rd_data;
    logic        uart_tx, uart_rx, rx_drv = 1'b1, loop = 1'b0;
    int          errors = 0, checks = 0, div = 26;

    assign uart_rx = loop ? uart_tx : rx_drv;
    always #5 clk = ~clk;

    io_uart dut (
        .clk(clk), .rst(rst),
        .io_bus_s_rd_en(rd_en), .io_bus_s_wr_en(wr_en), .io_bus_s_cs(cs),
        .io_bus_s_address(address), .io_bus_s_wr_data(wr_data),
        .io_bus_uart_rd_data(rd_data), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    function automatic int bp();
        return 16 * (div + 1);
    endfunction

    task automatic bus_cycle(input logic c, r, w, input logic [1:0] sel, input logic [31:0] d,
                             output logic [31:0] v);
        @(negedge clk);
        cs = c; rd_en = r; wr_en = w; address = {28'd0, sel, 2'b00}; wr_data = d;
        @(negedge clk);
        cs = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        v = rd_data;
    endtask

    task automatic write_reg(input logic [1:0] sel, input logic [31:0] d);
        logic [31:0] v;
        bus_cycle(1'b1, 1'b0, 1'b1, sel, d, v);
    endtask

    task automatic read_reg(input logic [1:0] sel, output logic [31:0] v);
        bus_cycle(1'b1, 1'b1, 1'b0, sel, 32'd0, v);
    endtask

    task automatic poll_status(input logic [31:0] mask, val, output logic [31:0] s);
        int n = 0;
        do begin
            read_reg(R_STATUS, s);
            n++;
        end while ((s & mask) !== val && n < 20000);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_clks);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (bp()) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_drv = b[k];
            repeat (bp()) @(negedge clk);
        end
        rx_drv = stop_val;
        repeat (stop_clks) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    task automatic capture(output logic [7:0] b, output bit ok);
        int n = 0;
        ok = 1'b0;
        b = '0;
        while (uart_tx !== 1'b0 && n < 40 * bp()) begin
            @(negedge clk);
            n++;
        end
        if (uart_tx !== 1'b0) return;
        repeat (bp() / 2) @(negedge clk);
        if (uart_tx !== 1'b0) return;
        for (int k = 0; k < 8; k++) begin
            repeat (bp()) @(negedge clk);
            b[k] = uart_tx;
        end
        repeat (bp()) @(negedge clk);
        ok = uart_tx === 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1 || rd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: uart_tx=%b rd_data=%h, want 1 and 0", uart_tx, rd_data);
        end
        rst = 1'b1;
        read_reg(R_STATUS, v);
        checks++;
        if (v !== 32'h06) begin errors++; $display("FAIL reset_status: got %h want 06", v); end
        @(negedge clk);
        checks++;
        if (rd_data !== 32'd0) begin errors++; $display("FAIL idle_rd_data: got %h want 0", rd_data); end
        read_reg(R_DIV, v);
        checks++;
        if (v !== 32'd26) begin errors++; $display("FAIL reset_divisor: got %0d want 26", v); end
        bus_cycle(1'b0, 1'b0, 1'b1, R_DIV, 32'h55, v);
        bus_cycle(1'b0, 1'b1, 1'b0, R_STATUS, 32'd0, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL cs_low_read: got %h want 0", v); end
        read_reg(R_DIV, v);
        checks++;
        if (v !== 32'd26) begin errors++; $display("FAIL cs_low_write: divisor %0d want 26", v); end
    endtask

    task automatic test_tx_frame();
        logic [31:0] v;
        logic [7:0]  b = 8'hA5;
        int          n = 0;
        div = 3;
        write_reg(R_DIV, 32'h0001_0003);
        read_reg(R_DIV, v);
        checks++;
        if (v !== 32'd3) begin errors++; $display("FAIL divisor_rw: got %h want 3", v); end
        write_reg(R_DATA, {24'hFFFF12, b});
        while (uart_tx !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
        for (int k = 0; k < 10; k++) begin
            logic exp_bit;
            int   bad = 0;
            exp_bit = k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
            for (int j = 0; j < bp(); j++) begin
                if (uart_tx !== exp_bit) bad++;
                @(negedge clk);
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL tx_bit%0d: %0d of %0d clocks not at required level %b", k, bad, bp(), exp_bit);
            end
        end
        read_reg(R_STATUS, v);
        checks++;
        if (v[1] !== 1'b1) begin errors++; $display("FAIL tx_idle_after_frame: status=%h want bit1=1", v); end
    endtask

    task automatic test_loopback();
        logic [31:0] v;
        loop = 1'b1;
        write_reg(R_DATA, 32'h3C);
        poll_status(32'h4, 32'h0, v);
        checks++;
        if (v[2] !== 1'b0) begin errors++; $display("FAIL loopback_arrival: status=%h want bit2=0", v); end
        read_reg(R_DATA, v);
        checks++;
        if (v !== 32'h03C) begin errors++; $display("FAIL loopback_data: got %h want 03c", v); end
        read_reg(R_DATA, v);
        checks++;
        if (v !== 32'h100) begin errors++; $display("FAIL loopback_empty: got %h want 100", v); end
        poll_status(32'h2, 32'h2, v);
        loop = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0]  q[$];
        logic [31:0] v, exp;
        bit          ovr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            logic [7:0] b = 8'($urandom);
            send_frame(b, 1'b1, bp());
            if (q.size() < 16) q.push_back(b);
            else ovr = 1'b1;
        end
        repeat (4) @(negedge clk);
        exp = 32'h2 | (q.size() == 16 ? 32'h8 : 32'h0) | (ovr ? 32'h10 : 32'h0) | (q.size() == 0 ? 32'h4 : 32'h0);
        read_reg(R_STATUS, v);
        checks++;
        if (v !== exp) begin errors++; $display("FAIL overrun_status: got %h want %h", v, exp); end
        for (int i = 0; i < 16; i++) begin
            logic [7:0] e = q.pop_front();
            read_reg(R_DATA, v);
            checks++;
            if (v !== {24'd0, e}) begin errors++; $display("FAIL overrun_read%0d: got %h want %h", i, v, e); end
        end
        write_reg(R_CLEAR, 32'h1);
        read_reg(R_STATUS, v);
        checks++;
        if (v !== 32'h06) begin errors++; $display("FAIL overrun_clear: got %h want 06", v); end
    endtask

    task automatic test_frame_err_glitch();
        logic [31:0] v;
        send_frame(8'($urandom), 1'b0, bp() * 3 / 4);
        repeat (bp()) @(negedge clk);
        read_reg(R_STATUS, v);
        checks++;
        if (v !== 32'h26) begin errors++; $display("FAIL frame_err_status: got %h want 26", v); end
        read_reg(R_DATA, v);
        checks++;
        if (v !== 32'h100) begin errors++; $display("FAIL frame_err_no_push: got %h want 100", v); end
        write_reg(R_CLEAR, 32'h2);
        read_reg(R_STATUS, v);
        checks++;
        if (v !== 32'h06) begin errors++; $display("FAIL frame_err_clear: got %h want 06", v); end
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (3 * (div + 1)) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * bp()) @(negedge clk);
        read_reg(R_STATUS, v);
        checks++;
        if (v !== 32'h06) begin errors++; $display("FAIL glitch_status: got %h want 06", v); end
        read_reg(R_DATA, v);
        checks++;
        if (v !== 32'h100) begin errors++; $display("FAIL glitch_no_push: got %h want 100", v); end
    endtask

    task automatic test_tx_full();
        logic [7:0]  sent[18];
        logic [7:0]  got[17];
        bit          ok[17];
        logic [31:0] s16, s17, v;
        int          low = 0;
        for (int i = 0; i < 18; i++) sent[i] = 8'($urandom);
        fork
            for (int i = 0; i < 17; i++) capture(got[i], ok[i]);
            for (int i = 0; i < 18; i++) begin
                write_reg(R_DATA, {24'd0, sent[i]});
                if (i == 15) read_reg(R_STATUS, s16);
                if (i == 16) read_reg(R_STATUS, s17);
            end
        join
        checks++;
        if (s16[0] !== 1'b0) begin errors++; $display("FAIL tx_not_full_16: status=%h want bit0=0", s16); end
        checks++;
        if (s17[0] !== 1'b1) begin errors++; $display("FAIL tx_full_17: status=%h want bit0=1", s17); end
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (!ok[i] || got[i] !== sent[i]) begin
                errors++;
                $display("FAIL tx_full_byte%0d: got %h framing_ok=%0d want %h", i, got[i], ok[i], sent[i]);
            end
        end
        for (int j = 0; j < 3 * bp(); j++) begin
            if (uart_tx !== 1'b1) low++;
            @(negedge clk);
        end
        checks++;
        if (low != 0) begin errors++; $display("FAIL tx_18th_dropped: line low %0d clocks, want 0", low); end
        read_reg(R_STATUS, v);
        checks++;
        if (v[1:0] !== 2'b10) begin errors++; $display("FAIL tx_drained: status=%h want bits[1:0]=10", v); end
    endtask

    task automatic test_random_loopback();
        logic [31:0] v;
        loop = 1'b1;
        for (int t = 0; t < 3; t++) begin
            logic [7:0] q[$];
            int         n = $urandom_range(2, 5);
            div = $urandom_range(1, 3);
            write_reg(R_DIV, div);
            for (int i = 0; i < n; i++) begin
                logic [7:0] b = 8'($urandom);
                q.push_back(b);
                write_reg(R_DATA, {24'd0, b});
            end
            poll_status(32'h2, 32'h2, v);
            repeat (8) @(negedge clk);
            for (int i = 0; i < n; i++) begin
                logic [7:0] e = q.pop_front();
                read_reg(R_DATA, v);
                checks++;
                if (v !== {24'd0, e}) begin errors++; $display("FAIL rand_t%0d_b%0d: got %h want %h", t, i, v, e); end
            end
            read_reg(R_STATUS, v);
            checks++;
            if (v !== 32'h06) begin errors++; $display("FAIL rand_t%0d_status: got %h want 06", t, v); end
        end
        loop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback();
        test_overrun();
        test_frame_err_glitch();
        test_tx_full();
        test_random_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
